// File: rtl/mem_responder_pkg.sv
// Shared types and default parameters for the mem_responder memory model.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    XFER
  } mem_rsp_state_t;

  localparam logic MEM_RW_WRITE = 1'b1;
  localparam logic MEM_RW_READ  = 1'b0;

  localparam int MEM_RSP_ADDR_W     = 8;
  localparam int MEM_RSP_DATA_W     = 32;
  localparam int MEM_RSP_LATENCY    = 4;
  localparam int MEM_RSP_LINE_WORDS = 4;

endpackage

// File: rtl/mem_responder_if.sv
// Cache-to-memory request/response handshake bundle.
interface mem_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();

  logic              MStrobe;
  logic              MRW;
  logic [ADDR_W-1:0] MAddr;
  logic [DATA_W-1:0] MWData;
  logic              MBusy;
  logic              MRdy;
  logic [DATA_W-1:0] MRData;

  modport master (
    output MStrobe, MRW, MAddr, MWData,
    input  MBusy, MRdy, MRData
  );

  modport slave (
    input  MStrobe, MRW, MAddr, MWData,
    output MBusy, MRdy, MRData
  );

endinterface

// File: rtl/mem_rsp_array.sv
// Word storage for mem_responder: synchronous write, asynchronous read, not reset.
module mem_rsp_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency main-memory responder (IDLE/WAIT/XFER handshake FSM).
// Define MEM_RESPONDER_BURST_EN for critical-word-first line bursts on reads.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W     = MEM_RSP_ADDR_W,
  parameter int DATA_W     = MEM_RSP_DATA_W,
  parameter int LATENCY    = MEM_RSP_LATENCY,
  parameter int LINE_WORDS = MEM_RSP_LINE_WORDS
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_responder_if.slave  bus
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  if (LATENCY < 1) begin : g_bad_latency
    $error("mem_responder: LATENCY must be >= 1");
  end
  if (LINE_WORDS < 1 || (LINE_WORDS & (LINE_WORDS - 1)) != 0 || LINE_WORDS > (1 << ADDR_W)) begin : g_bad_line
    $error("mem_responder: LINE_WORDS must be a power of two no larger than the storage");
  end

  mem_rsp_state_t    state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rdy_q;
  logic [DATA_W-1:0] rdata_q;

  logic              accept;
  logic              last_beat;
  logic              we;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;

`ifdef MEM_RESPONDER_BURST_EN
  localparam int IDX_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS - 1);
  logic [IDX_W-1:0] beat_idx;

  // In XFER the read port looks one beat ahead, wrapping within the line.
  always_comb begin
    last_beat = (rw_q == MEM_RW_WRITE) || (beat_idx == IDX_W'(LINE_WORDS - 1));
    raddr     = addr_q;
    if (state == XFER)
      raddr = (addr_q & ~LINE_MASK)
            | ((addr_q + ADDR_W'(beat_idx) + ADDR_W'(1)) & LINE_MASK);
  end
`else
  assign last_beat = 1'b1;
  assign raddr     = addr_q;
`endif

  // The final XFER edge doubles as the first IDLE edge, so a still-high
  // MStrobe there starts the next request (LATENCY+1 spacing).
  assign accept = bus.MStrobe && ((state == IDLE) || (state == XFER && last_beat));
  assign we     = (state == WAIT) && (cnt == '0) && (rw_q == MEM_RW_WRITE);

  mem_rsp_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk  (clk),
    .we   (we),
    .waddr(addr_q),
    .wdata(wdata_q),
    .raddr(raddr),
    .rdata(rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      rw_q    <= MEM_RW_READ;
      wdata_q <= '0;
      rdy_q   <= 1'b0;
      rdata_q <= '0;
`ifdef MEM_RESPONDER_BURST_EN
      beat_idx <= '0;
`endif
    end else if (accept) begin
      state   <= WAIT;
      cnt     <= CNT_LOAD;
      addr_q  <= bus.MAddr;
      rw_q    <= bus.MRW;
      wdata_q <= bus.MWData;
      rdy_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state <= XFER;
            rdy_q <= 1'b1;
            if (rw_q == MEM_RW_READ) rdata_q <= rdata;
`ifdef MEM_RESPONDER_BURST_EN
            beat_idx <= '0;
`endif
          end
        end
        XFER: begin
          if (last_beat) begin
            state <= IDLE;
            rdy_q <= 1'b0;
          end
`ifdef MEM_RESPONDER_BURST_EN
          else begin
            beat_idx <= beat_idx + IDX_W'(1);
            rdata_q  <= rdata;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.MBusy  = (state != IDLE);
  assign bus.MRdy   = rdy_q;
  assign bus.MRData = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: LATENCY=4 and LATENCY=1 instances with scoreboards.
module tb_mem_responder;

  localparam int L4 = 4;
  localparam int L1 = 1;
`ifdef MEM_RESPONDER_BURST_EN
  localparam int BURST_BEATS = 4;
`else
  localparam int BURST_BEATS = 1;
`endif

  typedef struct packed {
    logic        rd;
    logic [31:0] d;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  exp_t        sb4[$];
  exp_t        sb1[$];
  logic [31:0] model [256];

  mem_responder_if #(.ADDR_W(8), .DATA_W(32)) bus4();
  mem_responder_if #(.ADDR_W(8), .DATA_W(32)) bus1();

  mem_responder #(.ADDR_W(8), .DATA_W(32), .LATENCY(L4), .LINE_WORDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4)
  );
  mem_responder #(.ADDR_W(8), .DATA_W(32), .LATENCY(L1), .LINE_WORDS(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitors: every MRdy beat must match a queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus4.MRdy === 1'b1) begin
      checks++;
      if (sb4.size() == 0) begin
        errors++;
        $display("FAIL mrdy4_unexpected: MRdy=1 with no request outstanding at %0t", $time);
      end else begin
        e = sb4.pop_front();
        if (e.rd && bus4.MRData !== e.d) begin
          errors++;
          $display("FAIL rdata4: got %h expected %h at %0t", bus4.MRData, e.d, $time);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus1.MRdy === 1'b1) begin
      checks++;
      if (sb1.size() == 0) begin
        errors++;
        $display("FAIL mrdy1_unexpected: MRdy=1 with no request outstanding at %0t", $time);
      end else begin
        e = sb1.pop_front();
        if (e.rd && bus1.MRData !== e.d) begin
          errors++;
          $display("FAIL rdata1: got %h expected %h at %0t", bus1.MRData, e.d, $time);
        end
      end
    end
  end

  function automatic logic [7:0] beat_addr(input logic [7:0] a, input int i);
    logic [7:0] mask;
    mask = 8'(BURST_BEATS - 1);
    return (a & ~mask) | ((a + 8'(i)) & mask);
  endfunction

  // One LATENCY=4 transaction with cycle-exact MBusy/MRdy checks.
  task automatic txn4(input logic rw, input logic [7:0] a, input logic [31:0] d, input bit garbage);
    int          beats;
    logic [31:0] last_word;
    beats = (rw == 1'b0) ? BURST_BEATS : 1;
    last_word = model[beat_addr(a, beats - 1)];
    for (int i = 0; i < beats; i++)
      sb4.push_back(rw ? exp_t'{1'b0, 32'h0} : exp_t'{1'b1, model[beat_addr(a, i)]});
    bus4.MStrobe = 1'b1;
    bus4.MRW     = rw;
    bus4.MAddr   = a;
    bus4.MWData  = d;
    @(posedge clk);
    #1 bus4.MStrobe = 1'b0;
    for (int j = 0; j <= L4 + beats; j++) begin
      @(negedge clk);
      checks++;
      if (bus4.MBusy !== (j < L4 + beats)) begin
        errors++;
        $display("FAIL busy4 addr=%h cyc=%0d: got %b expected %b", a, j, bus4.MBusy, (j < L4 + beats));
      end
      checks++;
      if (bus4.MRdy !== (j >= L4 && j < L4 + beats)) begin
        errors++;
        $display("FAIL rdy4 addr=%h cyc=%0d: got %b expected %b", a, j, bus4.MRdy, (j >= L4 && j < L4 + beats));
      end
      if (!rw && j == L4 + beats) begin
        checks++;
        if (bus4.MRData !== last_word) begin
          errors++;
          $display("FAIL rdata4_hold addr=%h: got %h expected %h", a, bus4.MRData, last_word);
        end
      end
      if (garbage && j < 2) begin
        bus4.MStrobe = (j == 0);
        bus4.MRW     = 1'($urandom);
        bus4.MAddr   = 8'($urandom);
        bus4.MWData  = $urandom;
      end else begin
        bus4.MStrobe = 1'b0;
      end
    end
    if (rw) model[a] = d;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus4.MStrobe = 1'b0; bus4.MRW = 1'b0; bus4.MAddr = '0; bus4.MWData = '0;
    bus1.MStrobe = 1'b0; bus1.MRW = 1'b0; bus1.MAddr = '0; bus1.MWData = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus4.MBusy !== 1'b0 || bus4.MRdy !== 1'b0 || bus4.MRData !== 32'h0) begin
      errors++;
      $display("FAIL reset4: busy=%b rdy=%b rdata=%h expected 0 0 00000000", bus4.MBusy, bus4.MRdy, bus4.MRData);
    end
    checks++;
    if (bus1.MBusy !== 1'b0 || bus1.MRdy !== 1'b0 || bus1.MRData !== 32'h0) begin
      errors++;
      $display("FAIL reset1: busy=%b rdy=%b rdata=%h expected 0 0 00000000", bus1.MBusy, bus1.MRdy, bus1.MRData);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_write_read;
    txn4(1'b1, 8'h10, 32'hDEADBEEF, 1'b0);
    txn4(1'b0, 8'h10, 32'h0, 1'b0);
    txn4(1'b1, 8'hFF, 32'h0BAD_F00D, 1'b0);
    txn4(1'b0, 8'hFF, 32'h0, 1'b0);
  endtask

  task automatic test_ignore_wait;
    txn4(1'b1, 8'h30, 32'h12345678, 1'b1);
    txn4(1'b0, 8'h30, 32'h0, 1'b0);
  endtask

  // Start a LATENCY=4 request and pulse reset at a chosen cycle after acceptance.
  task automatic reset_during(input logic rw, input logic [7:0] a, input logic [31:0] d, input int at_j);
    if (!rw) sb4.push_back(exp_t'{1'b1, model[a]});
    bus4.MStrobe = 1'b1;
    bus4.MRW     = rw;
    bus4.MAddr   = a;
    bus4.MWData  = d;
    @(posedge clk);
    #1 bus4.MStrobe = 1'b0;
    for (int j = 0; j <= at_j; j++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus4.MRdy !== 1'b0 || bus4.MBusy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid addr=%h cyc=%0d: rdy=%b busy=%b expected 0 0", a, at_j, bus4.MRdy, bus4.MBusy);
    end
    sb4.delete();
    sb1.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset_mid;
    txn4(1'b1, 8'h20, 32'h000000AA, 1'b0);
    reset_during(1'b1, 8'h20, 32'h00000055, 2);
    txn4(1'b0, 8'h20, 32'h0, 1'b0);
    reset_during(1'b0, 8'h20, 32'h0, L4);
    txn4(1'b0, 8'h20, 32'h0, 1'b0);
  endtask

  // LATENCY=1 with MStrobe held high: one MRdy every two cycles, one per request.
  task automatic stream1(input logic rw, input int n);
    sb1.push_back(exp_t'{!rw, 32'hC0DE_0000});
    bus1.MStrobe = 1'b1;
    bus1.MRW     = rw;
    bus1.MAddr   = 8'h00;
    bus1.MWData  = 32'hC0DE_0000;
    @(posedge clk);
    for (int j = 0; j <= 2 * n; j++) begin
      @(negedge clk);
      checks++;
      if (bus1.MRdy !== (j % 2 == 1 && j < 2 * n)) begin
        errors++;
        $display("FAIL rdy1_stream rw=%b cyc=%0d: got %b expected %b", rw, j, bus1.MRdy, (j % 2 == 1 && j < 2 * n));
      end
      checks++;
      if (bus1.MBusy !== (j < 2 * n)) begin
        errors++;
        $display("FAIL busy1_stream rw=%b cyc=%0d: got %b expected %b", rw, j, bus1.MBusy, (j < 2 * n));
      end
      if (j % 2 == 0 && j < 2 * n - 2) begin
        bus1.MAddr  = 8'(j / 2 + 1);
        bus1.MWData = 32'hC0DE_0000 + 32'(j / 2 + 1);
        sb1.push_back(exp_t'{!rw, 32'hC0DE_0000 + 32'(j / 2 + 1)});
      end else if (j == 2 * n - 2) begin
        bus1.MStrobe = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back;
    stream1(1'b1, 4);
`ifndef MEM_RESPONDER_BURST_EN
    stream1(1'b0, 4);
`endif
  endtask

`ifdef MEM_RESPONDER_BURST_EN
  task automatic test_burst;
    for (int i = 0; i < 4; i++) txn4(1'b1, 8'(8'h40 + i), 32'(32'hA0 + i), 1'b0);
    txn4(1'b0, 8'h42, 32'h0, 1'b0);
    txn4(1'b0, 8'h40, 32'h0, 1'b0);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_read();
    test_ignore_wait();
    test_reset_mid();
    test_back_to_back();
`ifdef MEM_RESPONDER_BURST_EN
    test_burst();
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sb4.size() != 0 || sb1.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: outstanding beats dut4=%0d dut1=%0d expected 0 0", sb4.size(), sb1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
